// File: rtl/xnor_pkg.sv
// rtl/xnor_pkg.sv - shared FSM encodings and elaboration helpers for the xnor datapath blocks
package xnor_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_ACCUM = 2'd1;
    localparam fsm_state_t ST_DONE  = 2'd2;

    // Ceiling log2 for elaboration-time widths; a bounded loop keeps it
    // acceptable to synthesis as a constant function.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/abs_unit.sv
// rtl/abs_unit.sv - combinational magnitude and sign of one signed element
//   x     : signed two's-complement element
//   mag   : unsigned |x|; the most negative input maps to 2^(WIDTH-1) exactly
//   is_pos: 1 when x >= 0 (zero counts as positive)
module abs_unit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] mag,
    output logic             is_pos
);

    // Negation is done modulo 2^WIDTH and read back unsigned, so -2^(WIDTH-1)
    // produces 2^(WIDTH-1) instead of overflowing.
    always_comb begin
        is_pos = ~x[WIDTH-1];
        mag    = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    end

endmodule

// File: rtl/vector_binarizer.sv
// rtl/vector_binarizer.sv - serial binarizer: sign bits plus mean-magnitude scale of a vector
//   clk, rst_n          : clock and synchronous active-low reset
//   in_vector, in_valid,
//   in_ready            : input vector handshake, element i at [i*TOTAL_WIDTH +: TOTAL_WIDTH]
//   sign_bits, alpha,
//   out_valid, out_ready: result handshake; bit i = (element i >= 0), alpha = mean |element|
module vector_binarizer
    import xnor_pkg::*;
#(
    parameter int TOTAL_WIDTH = 32,
    parameter int VECTOR_SIZE = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [TOTAL_WIDTH*VECTOR_SIZE-1:0] in_vector,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [VECTOR_SIZE-1:0]             sign_bits,
    output logic [TOTAL_WIDTH-1:0]             alpha,
    output logic                               out_valid,
    input  logic                               out_ready
);

    localparam int CNT_W = clog2(VECTOR_SIZE);
    localparam int ACC_W = TOTAL_WIDTH + CNT_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VECTOR_SIZE - 1);

    fsm_state_t                         state;
    logic [TOTAL_WIDTH*VECTOR_SIZE-1:0] hold_vec;
    logic [ACC_W-1:0]                   acc;
    logic [CNT_W-1:0]                   cnt;
    logic [VECTOR_SIZE-1:0]             sign_r;
    logic [TOTAL_WIDTH-1:0]             alpha_r;

    logic [TOTAL_WIDTH-1:0]             elem_mag;
    logic                               elem_pos;
    logic [ACC_W-1:0]                   acc_next;

    // The holding register shifts down one element per cycle, so the single
    // abs_unit always looks at the low slot and needs no wide mux.
    abs_unit #(
        .WIDTH (TOTAL_WIDTH)
    ) u_abs (
        .x      (hold_vec[TOTAL_WIDTH-1:0]),
        .mag    (elem_mag),
        .is_pos (elem_pos)
    );

    // log2(VECTOR_SIZE) guard bits mean the sum of VECTOR_SIZE magnitudes fits.
    assign acc_next = acc + ACC_W'(elem_mag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_vec <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign_r   <= '0;
            alpha_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        hold_vec <= in_vector;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    hold_vec    <= hold_vec >> TOTAL_WIDTH;
                    sign_r[cnt] <= elem_pos;
                    acc         <= acc_next;
                    cnt         <= cnt + CNT_W'(1);
                    if (cnt == LAST_IDX) begin
                        // Dropping the low CNT_W bits divides by the power-of-two
                        // size and truncates toward zero (the sum is unsigned).
                        alpha_r <= acc_next[ACC_W-1:CNT_W];
                        cnt     <= '0;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign sign_bits = sign_r;
    assign alpha     = alpha_r;

endmodule

// File: tb/tb_vector_binarizer.sv
// tb/tb_vector_binarizer.sv - directed scoreboard bench for vector_binarizer
module tb_vector_binarizer;

    localparam int TW = 32;
    localparam int VS = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [TW*VS-1:0]     in_vector;
    logic                 in_valid;
    logic                 in_ready;
    logic [VS-1:0]        sign_bits;
    logic [TW-1:0]        alpha;
    logic                 out_valid;
    logic                 out_ready;

    typedef struct {
        logic [VS-1:0] sb;
        logic [TW-1:0] al;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    vector_binarizer #(
        .TOTAL_WIDTH (TW),
        .VECTOR_SIZE (VS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vector (in_vector),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_bits (sign_bits),
        .alpha     (alpha),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [TW*VS-1:0] v);
        exp_t            e;
        longint          sum;
        logic signed [TW-1:0] x;
        sum  = 0;
        e.sb = '0;
        for (int i = 0; i < VS; i++) begin
            x       = v[i*TW +: TW];
            e.sb[i] = (x >= 0);
            if (x < 0) sum += -longint'(x);
            else       sum += longint'(x);
        end
        e.al = TW'(sum / VS);
        return e;
    endfunction

    function automatic logic [TW*VS-1:0] pattern(input logic [TW-1:0] even, input logic [TW-1:0] odd);
        logic [TW*VS-1:0] v;
        for (int i = 0; i < VS; i++) begin
            v[i*TW +: TW] = (i % 2 == 0) ? even : odd;
        end
        return v;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input string tag, input logic [TW*VS-1:0] v);
        in_vector = v;
        in_valid  = 1'b1;
        check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sbq.push_back(model(v));
        check({tag, "_in_ready_accum"}, 64'(in_ready), 64'd0);
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(VS));
    endtask

    task automatic drain(input string tag);
        exp_t e;
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
        if (sbq.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            check({tag, "_sign_bits"}, 64'(sign_bits), 64'(e.sb));
            check({tag, "_alpha"}, 64'(alpha), 64'(e.al));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run(input string tag, input logic [TW*VS-1:0] v);
        send(tag, v);
        wait_out(tag);
        drain(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t held;
        exp_t dropped;
        int   seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_vector = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sign_bits", 64'(sign_bits), 64'd0);
        check("reset_alpha", 64'(alpha), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("all4", pattern(32'd4, 32'd4));
        check("all4_model_alpha", 64'(model(pattern(32'd4, 32'd4)).al), 64'd4);
        run("alt8", pattern(-32'sd8, 32'd8));
        in_vector = '0;
        in_vector[TW-1:0] = 32'd1;
        run("one", in_vector);
        run("minneg", pattern(32'h8000_0000, 32'h8000_0000));
        run("mixed", {32'hFFFF_FFFF, 32'd100, 32'h7FFF_FFFF, -32'sd37,
                      32'd0, -32'sd1000, 32'd12345, 32'h8000_0001});

        // Stall in DONE while a new vector is offered.
        send("stall", pattern(-32'sd8, 32'd8));
        wait_out("stall");
        held = sbq[0];
        in_vector = pattern(32'd99, 32'd99);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_sign_bits", 64'(sign_bits), 64'(held.sb));
            check("stall_alpha", 64'(alpha), 64'(held.al));
        end
        in_valid = 1'b0;
        drain("stall");
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("stall_not_queued", 64'(seen), 64'd0);

        // Reset while element 3 is being processed.
        send("midrst", pattern(32'd50, -32'sd50));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dropped = sbq.pop_back();
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_result", 64'(seen), 64'd0);
        run("after_rst", pattern(32'd4, 32'd4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vector_binarizer.md
VECTOR_BINARIZER -- requirements
Module: vector_binarizer

Interface
REQ-001 SHALL have parameter TOTAL_WIDTH, default 32: width of one signed two's-complement element and of alpha.
REQ-002 SHALL have parameter VECTOR_SIZE, default 8: elements per vector; power of two and at least 2.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port in_vector, input, TOTAL_WIDTH*VECTOR_SIZE bits: element i occupies bits [i*TOTAL_WIDTH +: TOTAL_WIDTH].
REQ-007 SHALL have port in_valid, input, 1 bit: in_vector is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept a vector.
REQ-009 SHALL have port sign_bits, output, VECTOR_SIZE bits: bit i is 1 when element i is >= 0 (+1) and 0 when it is negative (-1).
REQ-010 SHALL have port alpha, output, TOTAL_WIDTH bits: unsigned mean of |element|.
REQ-011 SHALL have port out_valid, output, 1 bit: sign_bits and alpha are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.

Function
REQ-013 SHALL implement the binarization that is the inverse of scalar-vector rescaling: in_vector ~ alpha * sign(in_vector).
REQ-014 SHALL use a three-state FSM with states IDLE, ACCUM and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; on in_valid&in_ready the FSM SHALL capture in_vector into a holding register, clear the accumulator and element counter, and go to ACCUM.
REQ-016 In ACCUM, the FSM SHALL process exactly one element per cycle in index order 0..VECTOR_SIZE-1: add |x_i| to the accumulator and register sign bit i.
REQ-017 On the edge that processes element VECTOR_SIZE-1, alpha SHALL be registered as (acc + |x_last|) >> log2(VECTOR_SIZE), the counter SHALL wrap to 0 and the FSM SHALL go to DONE.
REQ-018 Latency SHALL be fixed: out_valid goes to 1 exactly VECTOR_SIZE cycles after the accept edge.
REQ-019 In DONE, out_valid SHALL be 1; sign_bits and alpha SHALL stay stable while out_ready=0.
REQ-020 On out_valid&out_ready the FSM SHALL return to IDLE, and in_ready SHALL rise the following cycle; there is no same-cycle bypass.
REQ-021 in_ready SHALL be 0 in ACCUM and DONE; in_valid in those states SHALL be ignored and not queued.
REQ-022 |x| SHALL be computed as an unsigned TOTAL_WIDTH-bit value, so that |-2^(TOTAL_WIDTH-1)| = 2^(TOTAL_WIDTH-1) with no overflow.
REQ-023 The accumulator SHALL be TOTAL_WIDTH+log2(VECTOR_SIZE) bits unsigned and SHALL never overflow.
REQ-024 Alpha SHALL be truncated toward zero, with no rounding, and SHALL keep the input fixed-point format.
REQ-025 Zero elements SHALL map to sign bit 1.

Reset
REQ-026 With rst_n=0 at a rising edge, the FSM SHALL go to IDLE, the counter and accumulator SHALL clear, and outputs SHALL be in_ready=1, out_valid=0, sign_bits=0, alpha=0.
REQ-027 Reset in ACCUM or DONE SHALL discard the partial or pending result; no out_valid SHALL follow from it.
REQ-028 Reset SHALL take priority over every handshake.

Structure
REQ-029 Shared package xnor_pkg SHALL hold the FSM state encodings (IDLE, ACCUM, DONE) and the clog2 constant function; the multiplier and binarizer SHALL both use it.
REQ-030 The design SHALL have one sub-module, abs_unit: combinational signed TOTAL_WIDTH in, unsigned magnitude plus sign bit out, instantiated once and time-shared across elements.

Verification (all scenarios at TOTAL_WIDTH=32, VECTOR_SIZE=8)
REQ-031 All elements = 4 -> alpha=4, sign_bits=8'hFF; out_valid exactly 8 cycles after accept.
REQ-032 Elements alternate -8 (element 0), +8, -8, ... -> alpha=8, sign_bits=8'hAA.
REQ-033 Element 0 = 1, others 0 -> alpha=0 (truncation), sign_bits=8'hFF (zero maps to +1).
REQ-034 All elements = 32'h8000_0000 -> alpha=32'h8000_0000, sign_bits=8'h00, no overflow.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a new vector -> outputs stable, in_ready=0, new vector not accepted; after out_ready=1, in_ready=1 the next cycle.
REQ-036 Assert rst_n=0 while element 3 is being processed -> next cycle in_ready=1, out_valid=0; a fresh vector of all 4 then yields alpha=4.
